// File: rtl/m_stage.sv
// Y86 memory stage: M pipeline register, data-memory read/write, status/writeback operands for W.
// Latency: 1 cycle E->M register, memory read/status combinational from M; stall holds M, bubble loads a NOP.
module m_stage #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_stall_i,
    input  logic        M_bubble_i,
    input  logic [2:0]  E_stat_i,
    input  logic [3:0]  E_icode_i,
    input  logic        e_Cnd_i,
    input  logic [31:0] e_valE_i,
    input  logic [31:0] E_valA_i,
    input  logic [3:0]  e_dstE_i,
    input  logic [3:0]  E_dstM_i,
    output logic [2:0]  M_stat_o,
    output logic [3:0]  M_icode_o,
    output logic        M_Cnd_o,
    output logic [31:0] M_valE_o,
    output logic [31:0] M_valA_o,
    output logic [3:0]  M_dstE_o,
    output logic [3:0]  M_dstM_o,
    output logic [31:0] m_valM_o,
    output logic [2:0]  m_stat_o
);
    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [31:0] val_e;
        logic [31:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
    } m_reg_t;

    localparam m_reg_t M_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, cnd: 1'b0,
                                    val_e: 32'd0, val_a: 32'd0,
                                    dst_e: R_NONE, dst_m: R_NONE};

    m_reg_t m_q, m_d;

    always_comb begin
        m_d = m_q;
        if (M_stall_i) begin
            m_d = m_q;
        end else if (M_bubble_i) begin
            m_d = M_BUBBLE;
        end else begin
            m_d = '{stat: E_stat_i, icode: E_icode_i, cnd: e_Cnd_i,
                    val_e: e_valE_i, val_a: E_valA_i,
                    dst_e: e_dstE_i, dst_m: E_dstM_i};
            // A not-taken conditional move must not write its destination.
            if (E_icode_i == I_CMOVXX && !e_Cnd_i) begin
                m_d.dst_e = R_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q <= M_BUBBLE;
        end else begin
            m_q <= m_d;
        end
    end

    logic [31:0] mem [MEM_WORDS];
    logic        mem_rd, mem_wr, addr_ok, mem_we;
    logic [31:0] mem_addr;
    logic [AW-1:0] mem_idx;

    always_comb begin
        mem_rd   = (m_q.icode == I_MRMOVL) || (m_q.icode == I_POPL) || (m_q.icode == I_RET);
        mem_wr   = (m_q.icode == I_RMMOVL) || (m_q.icode == I_PUSHL) || (m_q.icode == I_CALL);
        mem_addr = ((m_q.icode == I_POPL) || (m_q.icode == I_RET)) ? m_q.val_a : m_q.val_e;
        addr_ok  = (mem_addr[1:0] == 2'b00) && (mem_addr < MEM_BYTES);
        mem_idx  = mem_addr[AW+1:2];
        mem_we   = mem_wr && addr_ok && (m_q.stat == STAT_AOK);
        m_valM_o = (mem_rd && addr_ok) ? mem[mem_idx] : 32'd0;
        m_stat_o = ((mem_rd || mem_wr) && !addr_ok) ? STAT_ADR : m_q.stat;
    end

    // Memory is deliberately outside reset: a write in M while rst is high still commits.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= m_q.val_a;
        end
    end

    assign M_stat_o  = m_q.stat;
    assign M_icode_o = m_q.icode;
    assign M_Cnd_o   = m_q.cnd;
    assign M_valE_o  = m_q.val_e;
    assign M_valA_o  = m_q.val_a;
    assign M_dstE_o  = m_q.dst_e;
    assign M_dstM_o  = m_q.dst_m;

endmodule

// File: tb/tb_m_stage.sv
// Randomized + directed bench for m_stage against an instruction-level reference model.
module tb_m_stage;
    localparam int MEM_WORDS = 1024;
    localparam int MEM_BYTES = 4 * MEM_WORDS;

    logic        clk = 1'b0;
    logic        rst, M_stall_i, M_bubble_i, e_Cnd_i;
    logic [2:0]  E_stat_i;
    logic [3:0]  E_icode_i, e_dstE_i, E_dstM_i;
    logic [31:0] e_valE_i, E_valA_i;
    logic [2:0]  M_stat_o, m_stat_o;
    logic [3:0]  M_icode_o, M_dstE_o, M_dstM_o;
    logic        M_Cnd_o;
    logic [31:0] M_valE_o, M_valA_o, m_valM_o;

    m_stage #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst), .M_stall_i(M_stall_i), .M_bubble_i(M_bubble_i),
        .E_stat_i(E_stat_i), .E_icode_i(E_icode_i), .e_Cnd_i(e_Cnd_i),
        .e_valE_i(e_valE_i), .E_valA_i(E_valA_i), .e_dstE_i(e_dstE_i), .E_dstM_i(E_dstM_i),
        .M_stat_o(M_stat_o), .M_icode_o(M_icode_o), .M_Cnd_o(M_Cnd_o),
        .M_valE_o(M_valE_o), .M_valA_o(M_valA_o), .M_dstE_o(M_dstE_o), .M_dstM_o(M_dstM_o),
        .m_valM_o(m_valM_o), .m_stat_o(m_stat_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the instruction currently in M plus a sparse memory image.
    int unsigned r_stat, r_icode, r_cnd, r_vale, r_vala, r_dste, r_dstm;
    int unsigned mem_model [int unsigned];

    function automatic bit is_read(int unsigned ic);
        return ic == 5 || ic == 9 || ic == 11;
    endfunction
    function automatic bit is_write(int unsigned ic);
        return ic == 4 || ic == 8 || ic == 10;
    endfunction
    function automatic int unsigned eff_addr();
        return (r_icode == 9 || r_icode == 11) ? r_vala : r_vale;
    endfunction
    function automatic bit addr_good(int unsigned a);
        return (a % 4 == 0) && (a < MEM_BYTES);
    endfunction

    task automatic load_bubble();
        r_stat = 1; r_icode = 1; r_cnd = 0; r_vale = 0; r_vala = 0; r_dste = 15; r_dstm = 15;
    endtask

    task automatic check_outputs();
        int unsigned a;
        bit acc;
        a   = eff_addr();
        acc = is_read(r_icode) || is_write(r_icode);
        chk("M_stat",  32'(M_stat_o),  r_stat);
        chk("M_icode", 32'(M_icode_o), r_icode);
        chk("M_Cnd",   32'(M_Cnd_o),   r_cnd);
        chk("M_valE",  M_valE_o,       r_vale);
        chk("M_valA",  M_valA_o,       r_vala);
        chk("M_dstE",  32'(M_dstE_o),  r_dste);
        chk("M_dstM",  32'(M_dstM_o),  r_dstm);
        chk("m_stat",  32'(m_stat_o),  (acc && !addr_good(a)) ? 32'd3 : r_stat);
        if (!(is_read(r_icode) && addr_good(a)))
            chk("m_valM", m_valM_o, 32'd0);
        else if (mem_model.exists(a))
            chk("m_valM", m_valM_o, mem_model[a]);
    endtask

    // One cycle: drive inputs, clock, advance the model, check after the edge.
    task automatic step(input bit r, input bit st, input bit bu,
                        input int unsigned stat, input int unsigned ic, input bit cnd,
                        input int unsigned vale, input int unsigned vala,
                        input int unsigned dste, input int unsigned dstm);
        rst = r; M_stall_i = st; M_bubble_i = bu;
        E_stat_i = 3'(stat); E_icode_i = 4'(ic); e_Cnd_i = cnd;
        e_valE_i = vale; E_valA_i = vala; e_dstE_i = 4'(dste); E_dstM_i = 4'(dstm);
        @(posedge clk);
        if (is_write(r_icode) && addr_good(eff_addr()) && r_stat == 1)
            mem_model[eff_addr()] = r_vala;
        if (r) load_bubble();
        else if (st) ;
        else if (bu) load_bubble();
        else begin
            r_stat = stat; r_icode = ic; r_cnd = cnd; r_vale = vale; r_vala = vala;
            r_dste = (ic == 2 && !cnd) ? 15 : dste; r_dstm = dstm;
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int unsigned ic, input int unsigned vale, input int unsigned vala);
        step(0, 0, 0, 1, ic, 1, vale, vala, 15, 15);
    endtask

    function automatic int unsigned pick_addr();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: return 32'h13;
            1: return MEM_BYTES;
            2: return MEM_BYTES - 4;
            3: return 32'hFFFF_FFFC;
            4: return 32'h100;
            default: return 4 * $urandom_range(0, 15);
        endcase
    endfunction

    initial begin
        load_bubble();
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_icode", 32'(M_icode_o), 32'd1);
        chk("rst_mstat", 32'(m_stat_o),  32'd1);
        chk("rst_valM",  m_valM_o,       32'd0);
        chk("rst_dstE",  32'(M_dstE_o),  32'hF);

        // Store then load; read-after-write in the next cycle.
        run(4, 32'h10, 32'hDEADBEEF);
        chk("st_mstat", 32'(m_stat_o), 32'd1);
        run(5, 32'h10, 32'h0);
        chk("ld_valM", m_valM_o, 32'hDEADBEEF);
        chk("ld_mstat", 32'(m_stat_o), 32'd1);

        run(10, 32'h100, 32'h5);
        run(11, 32'h0, 32'h100);
        chk("pop_valM", m_valM_o, 32'h5);
        run(8, 32'h200, 32'h40);
        run(9, 32'h0, 32'h200);
        chk("ret_valM", m_valM_o, 32'h40);

        // Address errors; address 0 must survive the out-of-range store.
        run(4, 32'h0, 32'h1234);
        run(5, 32'h13, 32'h0);
        chk("misal_stat", 32'(m_stat_o), 32'd3);
        chk("misal_valM", m_valM_o, 32'd0);
        run(4, MEM_BYTES, 32'h1);
        chk("oob_stat", 32'(m_stat_o), 32'd3);
        run(5, 32'h0, 32'h0);
        chk("addr0_keep", m_valM_o, 32'h1234);

        step(0, 0, 0, 1, 2, 0, 32'h7, 32'h0, 3, 15);
        chk("cmov_nt", 32'(M_dstE_o), 32'hF);
        step(0, 0, 0, 1, 2, 1, 32'h7, 32'h0, 3, 15);
        chk("cmov_t", 32'(M_dstE_o), 32'd3);

        step(0, 0, 0, 1, 6, 1, 32'h55, 32'h66, 2, 15);
        step(0, 1, 0, 4, 5, 0, 32'h99, 32'h88, 7, 6);
        chk("stall_icode", 32'(M_icode_o), 32'd6);
        chk("stall_valE", M_valE_o, 32'h55);
        step(0, 1, 1, 1, 5, 0, 32'h99, 32'h88, 7, 6);
        chk("both_icode", 32'(M_icode_o), 32'd6);
        step(0, 0, 1, 1, 5, 0, 32'h99, 32'h88, 7, 6);
        chk("bub_icode", 32'(M_icode_o), 32'd1);
        chk("bub_dstE", 32'(M_dstE_o), 32'hF);
        chk("bub_dstM", 32'(M_dstM_o), 32'hF);

        step(0, 0, 0, 2, 4, 1, 32'h0, 32'hBAD0, 15, 15);
        chk("hlt_mstat", 32'(m_stat_o), 32'd2);
        run(5, 32'h0, 32'h0);
        chk("hlt_nowr", m_valM_o, 32'h1234);

        // Write in M while rst is high still commits.
        run(4, 32'h20, 32'hCAFE);
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        run(5, 32'h20, 32'h0);
        chk("rst_wr", m_valM_o, 32'hCAFE);

        for (int i = 0; i < 3000; i++) begin
            int unsigned ic, stat, a;
            ic   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                 : 32'(($urandom_range(0, 1) == 0) ? 4 + 6 * $urandom_range(0, 1) : 5 + 6 * $urandom_range(0, 1));
            stat = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 4) : 1;
            a    = pick_addr();
            step($urandom_range(0, 60) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 stat, ic, 1'($urandom), a, ($urandom_range(0, 1) == 0) ? a : $urandom,
                 $urandom_range(0, 15), $urandom_range(0, 15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
